// File: rtl/input_loader_pkg.sv
// Shared constants and state type for the input buffer loader.
// Geometry of the activation buffer and SRAM word packing.
package input_loader_pkg;

  localparam int BIN_LEN         = 8;
  localparam int INPUT_HEIGHT    = 4;
  localparam int INPUT_WIDTH     = 8;
  localparam int INPUT_SRAM_LEN  = 4;
  localparam int SRAM_ADDR_W     = 12;
  localparam int MAX_OUTSTANDING = 4;

  localparam int CPR    = INPUT_WIDTH / INPUT_SRAM_LEN;
  localparam int TOTAL  = INPUT_HEIGHT * CPR;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int ROW_W  = $clog2(INPUT_HEIGHT);
  localparam int COL_W  = $clog2(INPUT_WIDTH);
  localparam int DATA_W = BIN_LEN * INPUT_SRAM_LEN;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } loader_state_t;

endpackage

// File: rtl/input_buffer_loader_buf_pos_counter.sv
// Row/column wrap counter giving the buffer slot of the next write.
// Column advances by one chunk; wrapping it bumps the row.
module buf_pos_counter
  import input_loader_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(INPUT_WIDTH - INPUT_SRAM_LEN);
  localparam logic [COL_W-1:0] COL_STEP =
    COL_W'(INPUT_SRAM_LEN);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_STEP;
      end
    end
  end

endmodule

// File: rtl/input_buffer_loader.sv
// Fills the input activation buffer from SRAM with a bounded
// number of in-flight chunk reads; one buffer write per return.
module input_buffer_loader
  import input_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SRAM_ADDR_W-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   sram_req,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic                   sram_gnt,
  input  logic                   sram_rvalid,
  input  logic [DATA_W-1:0]      sram_rdata,
  output logic                   buf_w_enable,
  output logic [DATA_W-1:0]      buf_SRAM_in,
  output logic [ROW_W-1:0]       buf_SRAM_r,
  output logic [COL_W-1:0]       buf_SRAM_c
);

  localparam logic [CNT_W-1:0] TOT = CNT_W'(TOTAL);
  localparam logic [OUT_W-1:0] MAXO = OUT_W'(MAX_OUTSTANDING);

  loader_state_t          state;
  logic [SRAM_ADDR_W-1:0] base;
  logic [CNT_W-1:0]       issue_cnt;
  logic [CNT_W-1:0]       ret_cnt;
  logic [OUT_W-1:0]       outst;
  logic [CNT_W-1:0]       issue_nx;
  logic [CNT_W-1:0]       ret_nx;
  logic [OUT_W-1:0]       outst_nx;
  logic                   hit_gnt;
  logic                   hit_ret;
  logic                   stray;
  logic                   go;
  logic [ROW_W-1:0]       pos_row;
  logic [COL_W-1:0]       pos_col;

  assign hit_gnt = sram_req & sram_gnt;
  assign hit_ret = sram_rvalid & (outst != '0);
  assign stray   = sram_rvalid & (outst == '0);
  assign go      = start & (state == IDLE);

  always_comb begin
    issue_nx = issue_cnt + CNT_W'(hit_gnt);
    ret_nx   = ret_cnt + CNT_W'(hit_ret);
    outst_nx = outst + OUT_W'(hit_gnt) - OUT_W'(hit_ret);
  end

  buf_pos_counter u_pos (
    .clock (clock),
    .reset (reset),
    .clear (go),
    .step  (hit_ret),
    .row   (pos_row),
    .col   (pos_col)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      base         <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      outst        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      sram_req     <= 1'b0;
      sram_addr    <= '0;
      buf_w_enable <= 1'b0;
      buf_SRAM_in  <= '0;
      buf_SRAM_r   <= '0;
      buf_SRAM_c   <= '0;
    end else begin
      done         <= 1'b0;
      buf_w_enable <= hit_ret;
      if (hit_ret) begin
        buf_SRAM_in <= sram_rdata;
        buf_SRAM_r  <= pos_row;
        buf_SRAM_c  <= pos_col;
      end
      // unsolicited return: data is dropped
      if (stray) err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            err       <= 1'b0;
            base      <= base_addr;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            outst     <= '0;
            sram_req  <= 1'b1;
            sram_addr <= base_addr;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_nx;
          ret_cnt   <= ret_nx;
          outst     <= outst_nx;
          sram_addr <= base + SRAM_ADDR_W'(issue_nx);
          if (issue_nx == TOT) begin
            sram_req <= 1'b0;
            state    <= DRAIN;
          end else begin
            sram_req <= (outst_nx < MAXO);
          end
        end
        DRAIN: begin
          ret_cnt <= ret_nx;
          outst   <= outst_nx;
          if (ret_nx == TOT) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer_loader.sv
// Bench for input_buffer_loader: SRAM responder plus a
// reference of addresses, write slots and handshake rules.
module tb_input_buffer_loader;
  import input_loader_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic [SRAM_ADDR_W-1:0] base_addr;
  logic                   busy, done, err;
  logic                   sram_req;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic                   sram_gnt;
  logic                   sram_rvalid;
  logic [DATA_W-1:0]      sram_rdata;
  logic                   buf_w_enable;
  logic [DATA_W-1:0]      buf_SRAM_in;
  logic [ROW_W-1:0]       buf_SRAM_r;
  logic [COL_W-1:0]       buf_SRAM_c;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  input_buffer_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .sram_req     (sram_req),
    .sram_addr    (sram_addr),
    .sram_gnt     (sram_gnt),
    .sram_rvalid  (sram_rvalid),
    .sram_rdata   (sram_rdata),
    .buf_w_enable (buf_w_enable),
    .buf_SRAM_in  (buf_SRAM_in),
    .buf_SRAM_r   (buf_SRAM_r),
    .buf_SRAM_c   (buf_SRAM_c)
  );

  typedef struct {
    int               base;
    int               lat;
    int               pct;
    int               poke;
    int               abort;
    logic [SRAM_ADDR_W-1:0] exp_last;
    int               exp_peak;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [DATA_W-1:0] mem(
    input logic [SRAM_ADDR_W-1:0] a);
    return {a[7:0] ^ 8'hA5, a[11:4], ~a[7:0], a[3:0], a[11:8]};
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, err, sram_req, sram_addr,
                buf_w_enable, buf_SRAM_in,
                buf_SRAM_r, buf_SRAM_c});
  endfunction

  task automatic run_fill(input vec_t v);
    int due_q[$];
    logic [SRAM_ADDR_W-1:0] adr_q[$];
    logic [SRAM_ADDR_W-1:0] ea;
    logic [SRAM_ADDR_W-1:0] last_a;
    int n_iss, n_ret, n_wr, cyc, last_wr, peak;
    int req_err, addr_err, busy_err;
    bit fin, g, exp_req;
    n_iss = 0; n_ret = 0; n_wr = 0; cyc = 0;
    last_wr = -1; peak = 0; last_a = '0;
    req_err = 0; addr_err = 0; busy_err = 0; fin = 0;
    @(negedge clock);
    start = 1'b1;
    base_addr = SRAM_ADDR_W'(v.base);
    for (int k = 0; k < 800 && !fin; k++) begin
      @(negedge clock);
      cyc++;
      start = (cyc == v.poke);
      base_addr = SRAM_ADDR_W'(v.base) ^ (start ? 12'h555 : 12'h000);
      // outputs of this cycle against the model
      if (buf_w_enable) begin
        ea = SRAM_ADDR_W'(v.base + n_wr);
        check("wr", 64'({buf_SRAM_in, buf_SRAM_r, buf_SRAM_c}),
              64'({mem(ea), ROW_W'(n_wr / CPR),
                   COL_W'((n_wr % CPR) * INPUT_SRAM_LEN)}));
        n_wr++;
        last_wr = cyc;
      end
      if (v.abort != 0 && n_wr == v.abort) begin
        reset = 1'b1; sram_gnt = 1'b0; sram_rvalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("abort_outs", all_outs(), 64'd0);
        return;
      end
      if (done) begin
        fin = 1;
        check("done_nwr", 64'(n_wr), 64'(TOTAL));
        check("done_lat", 64'(cyc - last_wr), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_err", 64'(err), 64'd0);
      end else if (!busy) begin
        busy_err++;
      end
      exp_req = !fin && n_iss < TOTAL &&
                (n_iss - n_ret) < MAX_OUTSTANDING;
      if (sram_req !== exp_req) req_err++;
      if (sram_req && sram_addr !== SRAM_ADDR_W'(v.base + n_iss))
        addr_err++;
      if (n_iss - n_ret > peak) peak = n_iss - n_ret;
      // inputs for this cycle
      g = ($urandom_range(99) < v.pct);
      sram_gnt = g;
      if (sram_req && g && !fin) begin
        last_a = sram_addr;
        due_q.push_back(cyc + v.lat);
        adr_q.push_back(sram_addr);
        n_iss++;
      end
      sram_rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        sram_rvalid = 1'b1;
        sram_rdata = mem(adr_q.pop_front());
        n_ret++;
      end
    end
    sram_gnt = 1'b0;
    sram_rvalid = 1'b0;
    check("finished", 64'(fin), 64'd1);
    check("req_rule", 64'(req_err), 64'd0);
    check("addr_rule", 64'(addr_err), 64'd0);
    check("busy_span", 64'(busy_err), 64'd0);
    check("last_addr", 64'(last_a),
          64'(v.abort == 0 ? v.exp_last
                           : SRAM_ADDR_W'(v.base + TOTAL - 1)));
    if (v.exp_peak != 0)
      check("peak", 64'(peak), 64'(v.exp_peak));
    @(negedge clock);
    check("done_pulse", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{12'h100, 2, 100, 0, 0, 12'h107, 2};
    vecs[1] = '{12'h000, 10, 100, 0, 0, 12'h007, 4};
    vecs[2] = '{12'h3A0, 3, 50, 0, 0, 12'h3A7, 0};
    vecs[3] = '{12'hFFE, 2, 100, 0, 0, 12'h005, 2};
    vecs[4] = '{12'h200, 4, 100, 3, 0, 12'h207, 4};
    vecs[5] = '{12'h050, 2, 100, 0, 3, 12'h000, 0};
    vecs[6] = '{12'h050, 1, 100, 0, 0, 12'h057, 1};

    reset = 1'b1; start = 1'b0; base_addr = '0;
    sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = '0;
    repeat (3) @(negedge clock);
    check("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_fill(vecs[i]);

    // unsolicited return while idle
    @(negedge clock);
    sram_rvalid = 1'b1;
    sram_rdata = 32'hDEADBEEF;
    @(negedge clock);
    sram_rvalid = 1'b0;
    check("stray_we", 64'(buf_w_enable), 64'd0);
    check("stray_err", 64'(err), 64'd1);

    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r.base = int'($urandom_range(4095));
      r.lat = int'($urandom_range(12, 1));
      r.pct = int'($urandom_range(100, 30));
      r.poke = 0;
      r.abort = 0;
      r.exp_last = SRAM_ADDR_W'(r.base + TOTAL - 1);
      r.exp_peak = 0;
      run_fill(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
